display_pixel_reader: RTL and testbench

Avalon-MM read master that scans the 16-bit display frame buffer out as a pixel stream. It walks a frame linearly from `BASE_ADDR` using pipelined reads with a fixed read latency, buffers the returned words in a small FIFO, and presents them on an Avalon-ST source with start/end-of-frame markers. It sits between the frame-buffer on-chip memory slave and the video timing/output block.

---
 rtl/display_pixel_reader.sv | 194 +++++++++++++++++++
 tb/tb_display_pixel_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_pixel_reader.sv
// ---------------------------------------------------------------------------
// display_pixel_reader
//
// Scans the 16-bit display frame buffer out as an Avalon-ST pixel stream.
// Issues pipelined Avalon-MM reads linearly from BASE_ADDR, captures the data
// returned after a fixed READ_LATENCY, buffers it in a small FIFO and
// presents it with start/end-of-frame markers.
//
// Ports:
//   clk, reset_n       sole clock, asynchronous active-low reset
//   enable             level; start/continue scanning frames
//   avm_address/read   word read address and read request (Avalon-MM master)
//   avm_waitrequest    slave stall
//   avm_readdata       read data, valid READ_LATENCY cycles after acceptance
//   st_data/valid      pixel stream (Avalon-ST source, ready latency 0)
//   st_ready           sink ready
//   st_sop/st_eop      first / last pixel of a frame
//   frame_done         one-cycle pulse after each frame's last pixel handshake
// ---------------------------------------------------------------------------
module display_pixel_reader #(
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_PIXELS = 76800,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [16:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [15:0] avm_readdata,
    output logic [15:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop,
    output logic        frame_done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1; // pointer width
    localparam int CW = PW + 1;                                   // occupancy width
    localparam int SW = CW + 1;                                   // occupancy + in-flight sum

    localparam logic [16:0] BASE  = 17'(BASE_ADDR);
    localparam logic [16:0] LAST  = 17'(FRAME_PIXELS - 1);
    localparam logic [SW-1:0] DEPTH = SW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]              state_q,     state_d;
    logic [16:0]             addr_q,      addr_d;
    logic [16:0]             issue_cnt_q, issue_cnt_d;
    logic [16:0]             out_cnt_q,   out_cnt_d;
    logic [READ_LATENCY-1:0] vld_pipe_q,  vld_pipe_d;
    logic [CW-1:0]           inflight_q,  inflight_d;
    logic [CW-1:0]           count_q,     count_d;
    logic [PW-1:0]           wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q,    rd_ptr_d;
    logic                    frame_done_q, frame_done_d;
    logic [15:0]             mem_q [FIFO_DEPTH];

    logic          room;
    logic          accept;
    logic          rtn;
    logic          pop;
    logic          eop_hs;
    logic [SW-1:0] committed;

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    // Credit check: every issued read already owns a FIFO slot, so the FIFO
    // can never overflow. A pop in the same cycle is not credited; that costs
    // nothing at full rate as long as FIFO_DEPTH > READ_LATENCY+1.
    assign committed = SW'(count_q) + SW'(inflight_q);
    assign room      = committed < DEPTH;

    // Request is a pure function of state: during a stall nothing that feeds
    // it can grow (no accepts), so avm_read and avm_address stay put.
    assign avm_read    = (state_q == S_FETCH) && room;
    assign avm_address = addr_q;
    assign accept      = avm_read && !avm_waitrequest;

    // Oldest tap of the latency pipe marks avm_readdata as valid this cycle.
    assign rtn = vld_pipe_q[READ_LATENCY-1];

    assign st_valid   = (count_q != '0);
    assign st_data    = mem_q[rd_ptr_q];
    assign st_sop     = st_valid && (out_cnt_q == 17'd0);
    assign st_eop     = st_valid && (out_cnt_q == LAST);
    assign pop        = st_valid && st_ready;
    assign eop_hs     = pop && (out_cnt_q == LAST);
    assign frame_done = frame_done_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_cnt_d  = issue_cnt_q;
        out_cnt_d    = out_cnt_q;
        frame_done_d = eop_hs;

        vld_pipe_d = (vld_pipe_q << 1) | READ_LATENCY'(accept);
        inflight_d = inflight_q + CW'(accept) - CW'(rtn);
        count_d    = count_q + CW'(rtn) - CW'(pop);
        wr_ptr_d   = rtn ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        if (pop) begin
            out_cnt_d = out_cnt_q + 17'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d     = S_FETCH;
                    addr_d      = BASE;
                    issue_cnt_d = 17'd0;
                    out_cnt_d   = 17'd0;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    addr_d      = addr_q + 17'd1;
                    issue_cnt_d = issue_cnt_q + 17'd1;
                    // Compare against the last index rather than the frame
                    // size so a full 2^17-pixel frame still terminates.
                    if (issue_cnt_q == LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The last pixel can only leave after the last read was
                // accepted, so the eop handshake always lands here.
                if (eop_hs) begin
                    addr_d      = BASE;
                    issue_cnt_d = 17'd0;
                    out_cnt_d   = 17'd0;
                    state_d     = enable ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = BASE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= BASE;
            issue_cnt_q  <= 17'd0;
            out_cnt_q    <= 17'd0;
            vld_pipe_q   <= '0;
            inflight_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_cnt_q  <= issue_cnt_d;
            out_cnt_q    <= out_cnt_d;
            vld_pipe_q   <= vld_pipe_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (rtn) begin
            mem_q[wr_ptr_q] <= avm_readdata;
        end
    end

endmodule

// File: tb/tb_display_pixel_reader.sv
module tb_display_pixel_reader;

    localparam int BASE  = 32'h100;
    localparam int FRAME = 8;
    localparam int RL    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        st_ready = 1'b1;
    logic [15:0] avm_readdata = 16'h0;
    logic [16:0] avm_address;
    logic        avm_read;
    logic [15:0] st_data;
    logic        st_valid, st_sop, st_eop, frame_done;

    always #5 clk = ~clk;

    display_pixel_reader #(
        .BASE_ADDR(BASE), .FRAME_PIXELS(FRAME), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .frame_done(frame_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [16:0] a);
        return 16'h1000 + a[15:0];
    endfunction

    // ---------------- memory slave model: fixed read latency ----------------
    logic        acc_s = 1'b0;
    logic [16:0] acc_a = '0;
    logic        mv [RL];
    logic [16:0] ma [RL];

    always begin
        @(posedge clk);
        #1;
        for (int i = RL - 1; i > 0; i--) begin
            mv[i] = mv[i-1];
            ma[i] = ma[i-1];
        end
        mv[0] = acc_s;
        ma[0] = acc_a;
        if (!reset_n) for (int i = 0; i < RL; i++) mv[i] = 1'b0;
        avm_readdata = mv[RL-1] ? mem_word(ma[RL-1]) : 16'($urandom);
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct packed { logic [15:0] d; logic sop; logic eop; } exp_t;
    exp_t q[$];

    int acc_k = 0, out_k = 0, outstanding = 0;
    int fd_count = 0, sop_count = 0;
    int mcyc = 0, acc0_cyc = 0, sop_cyc = 0, span = 0, lat = 0;
    logic        fd_pend = 1'b0, prev_stall = 1'b0, prev_bp = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    logic        prev_sop = 1'b0, prev_eop = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        mcyc++;
        if (!reset_n) begin
            q.delete();
            acc_k = 0; out_k = 0; outstanding = 0;
            fd_pend = 1'b0; prev_stall = 1'b0; prev_bp = 1'b0; acc_s = 1'b0;
        end else begin
            chk("frame_done", frame_done, fd_pend);
            fd_pend = 1'b0;
            if (frame_done) fd_count++;
            chk("occupancy_bound", outstanding <= DEPTH, 1);
            if (prev_stall) begin
                chk("stall_read_held", avm_read, 1);
                chk("stall_addr_held", avm_address, prev_addr);
            end
            if (prev_bp) begin
                chk("bp_valid_held", st_valid, 1);
                chk("bp_data_held", st_data, prev_data);
                chk("bp_sop_held", st_sop, prev_sop);
                chk("bp_eop_held", st_eop, prev_eop);
            end
            if (st_valid) begin
                chk("valid_has_pixel", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("pixel_data", st_data, q[0].d);
                    chk("pixel_sop", st_sop, q[0].sop);
                    chk("pixel_eop", st_eop, q[0].eop);
                end
            end else begin
                chk("idle_sop", st_sop, 0);
                chk("idle_eop", st_eop, 0);
            end
            if (st_valid && st_ready && q.size() != 0) begin
                e = q.pop_front();
                outstanding--;
                out_k++;
                if (e.sop) begin
                    sop_count++;
                    lat = mcyc - acc0_cyc;
                    sop_cyc = mcyc;
                end
                if (e.eop) begin
                    fd_pend = 1'b1;
                    span = mcyc - sop_cyc;
                    out_k = 0;
                end
            end
            if (avm_read && !avm_waitrequest) begin
                chk("read_addr", avm_address, BASE + acc_k);
                if (acc_k == 0) acc0_cyc = mcyc;
                e.d = mem_word(17'(BASE + acc_k));
                e.sop = (acc_k == 0);
                e.eop = (acc_k == FRAME - 1);
                q.push_back(e);
                outstanding++;
                acc_k = (acc_k + 1) % FRAME;
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            prev_bp    = st_valid && !st_ready;
            prev_data  = st_data;
            prev_sop   = st_sop;
            prev_eop   = st_eop;
            acc_s      = avm_read && !avm_waitrequest;
            acc_a      = avm_address;
        end
    end

    // ---------------- stimulus ----------------
    int scyc = 0;

    // wmode: 0 none, 1 every other cycle, 2 random; rmode: 0 ready, 1 random, 2 stalled
    task automatic step(input int wmode, input int rmode);
        @(posedge clk);
        #1;
        scyc++;
        case (wmode)
            0:       avm_waitrequest = 1'b0;
            1:       avm_waitrequest = scyc[0];
            default: avm_waitrequest = ($urandom_range(0, 2) == 0);
        endcase
        case (rmode)
            0:       st_ready = 1'b1;
            1:       st_ready = ($urandom_range(0, 3) != 0);
            default: st_ready = 1'b0;
        endcase
    endtask

    task automatic wait_fd(input int target, input int wmode, input int rmode);
        int n = 0;
        while (fd_count < target && n < 2000) begin
            step(wmode, rmode);
            n++;
        end
        chk("frame_done_timeout", fd_count, target);
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        step(0, 0);
        enable = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 6; i++) step(0, 0);
        chk({tag, "_idle_read"}, avm_read, 0);
        chk({tag, "_idle_valid"}, st_valid, 0);
    endtask

    initial begin
        int n;
        int base_fd;
        int base_sop;

        // reset state
        step(0, 0);
        step(0, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, BASE);
        chk("rst_valid", st_valid, 0);
        chk("rst_sop", st_sop, 0);
        chk("rst_eop", st_eop, 0);
        chk("rst_frame_done", frame_done, 0);
        reset_n = 1'b1;
        step(0, 0);
        step(0, 0);

        // single frame, full rate
        chk("a_pre_read", avm_read, 0);
        pulse_enable();
        chk("a_first_read", avm_read, 1);
        chk("a_first_addr", avm_address, BASE);
        wait_fd(1, 0, 0);
        chk("a_first_valid_latency", lat, RL + 1);
        chk("a_throughput_span", span, FRAME - 1);
        check_idle("a");

        // single frame, waitrequest every other cycle
        pulse_enable();
        wait_fd(2, 1, 0);
        check_idle("b");

        // backpressure: sink stalls for 20 cycles after first valid
        pulse_enable();
        n = 0;
        while (!st_valid && n < 50) begin step(0, 0); n++; end
        chk("c_valid_seen", st_valid, 1);
        for (int i = 0; i < 20; i++) step(0, 2);
        wait_fd(3, 0, 0);
        check_idle("c");

        // enable held for three frames
        base_sop = sop_count;
        enable = 1'b1;
        wait_fd(5, 0, 0);
        enable = 1'b0;
        wait_fd(6, 0, 0);
        check_idle("d");
        chk("d_fd_count", fd_count, 6);
        chk("d_sop_count", sop_count - base_sop, 3);

        // enable dropped after pixel 3
        enable = 1'b1;
        n = 0;
        while (out_k < 4 && n < 100) begin step(0, 0); n++; end
        chk("e_pixel3_seen", out_k >= 4, 1);
        enable = 1'b0;
        wait_fd(7, 0, 0);
        check_idle("e");
        chk("e_fd_count", fd_count, 7);

        // randomized stalls and backpressure over several frames
        for (int r = 0; r < 4; r++) begin
            base_fd = fd_count;
            enable = 1'b1;
            wait_fd(base_fd + 1 + int'($urandom_range(0, 1)), 2, 1);
            enable = 1'b0;
            wait_fd(fd_count + 1, 2, 1);
            check_idle("g");
        end

        // reset with reads in flight
        pulse_enable();
        n = 0;
        while (outstanding < 3 && n < 50) begin step(0, 2); n++; end
        chk("f_outstanding_built", outstanding >= 3, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("f_rst_read", avm_read, 0);
        chk("f_rst_valid", st_valid, 0);
        chk("f_rst_sop", st_sop, 0);
        chk("f_rst_eop", st_eop, 0);
        chk("f_rst_frame_done", frame_done, 0);
        chk("f_rst_addr", avm_address, BASE);
        step(0, 0);
        step(0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            chk("f_no_stale_valid", st_valid, 0);
        end
        base_fd = fd_count;
        base_sop = sop_count;
        pulse_enable();
        wait_fd(base_fd + 1, 0, 0);
        chk("f_restart_sop", sop_count - base_sop, 1);
        check_idle("f");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
